wave_sequencer: RTL

- Programmable controller for the WaveGen square-wave generator; drives its on/off time inputs and restart, stepping through a small table of (on, off, repeat) entries.
- Sits between board-level controls and one WaveGen instance; watches WaveGen's output to time entry changes on period boundaries.
- Supports one-shot or looping playback, with a watchdog that skips entries whose wave never toggles.

---
 rtl/wave_sequencer_pkg.sv | 11 +
 rtl/wave_seq_table.sv | 16 +
 rtl/wave_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/wave_sequencer_pkg.sv
// wave_sequencer_pkg: shared state encoding and table entry layout for the wave sequencer.
package wave_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, RUN, DONE} state_t;
  localparam int ON_MSB = 11;
  localparam int ON_LSB = 8;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 4;
  localparam int REP_MSB = 3;
  localparam int REP_LSB = 0;
  localparam logic [3:0] TERMINATOR = 4'd0;
endpackage

// File: rtl/wave_seq_table.sv
// wave_seq_table: DEPTH x 12 entry register file, synchronous write, asynchronous read.
module wave_seq_table #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [11:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [11:0]              rd_data
);
  logic [11:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: steps a WaveGen through a table of (on, off, repeat) entries,
// switching settings only on period boundaries, with a per-entry watchdog.
module wave_sequencer
  import wave_sequencer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1048575,
  parameter int TW      = 20
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [11:0]              wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     wave_in,
  output logic                     wg_reset,
  output logic [3:0]               on_time,
  output logic [3:0]               off_time,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  state_t        state;
  logic [AW-1:0] idx;
  logic [11:0]   entry;
  logic [3:0]    rep, cnt;
  logic [TW-1:0] wd;
  logic          loop_q, prev, rise, timeout, finish, end_loop, last_idx;

  wave_seq_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (entry)
  );

  assign busy     = (state == APPLY) || (state == RUN);
  assign rise     = wave_in && !prev;
  assign finish   = rise && (cnt + 4'd1 == rep);
  assign timeout  = !rise && (wd == TW'(TIMEOUT - 1));
  assign last_idx = idx == AW'(DEPTH - 1);
  // From the last slot idx is nonzero, so this also covers the implicit end-of-table wrap.
  assign end_loop = loop_q && (idx != '0);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      wg_reset <= 1'b1;
      on_time  <= '0;
      off_time <= '0;
      done     <= 1'b0;
      step_idx <= '0;
      err      <= 1'b0;
      idx      <= '0;
      loop_q   <= 1'b0;
      rep      <= '0;
      cnt      <= '0;
      wd       <= '0;
      prev     <= 1'b1;
    end else begin
      done <= 1'b0;
      prev <= wave_in;
      case (state)
        IDLE, DONE:
          if (start && !stop) begin
            state  <= APPLY;
            idx    <= '0;
            loop_q <= loop;
            err    <= 1'b0;
          end
        APPLY: begin
          prev <= 1'b1;
          if (stop) state <= IDLE;
          else if (entry[REP_MSB:REP_LSB] == TERMINATOR) begin
            state <= end_loop ? APPLY : DONE;
            done  <= !end_loop;
            if (end_loop) idx <= '0;
          end else begin
            on_time  <= entry[ON_MSB:ON_LSB];
            off_time <= entry[OFF_MSB:OFF_LSB];
            rep      <= entry[REP_MSB:REP_LSB];
            cnt      <= '0;
            wd       <= '0;
            step_idx <= idx;
            wg_reset <= 1'b0;
            state    <= RUN;
          end
        end
        RUN:
          if (stop) begin
            state    <= IDLE;
            wg_reset <= 1'b1;
          end else if (finish || timeout) begin
            err      <= err || timeout;
            wg_reset <= 1'b1;
            if (last_idx) begin
              state <= end_loop ? APPLY : DONE;
              done  <= !end_loop;
              if (end_loop) idx <= '0;
            end else begin
              state <= APPLY;
              idx   <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 4'(rise);
            wd  <= rise ? '0 : wd + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
